// File: rtl/rom_dl_writer_if.sv
// Download-side bus between the HPS byte source and the ROM writer.
// The master drives the download stream; the slave returns the ROM
// write port signals and the load status flags.
interface rom_dl_writer_if #(
  parameter int AW = 16
);
  logic          DL_EN;
  logic          DL_WR;
  logic [7:0]    DL_DT;
  logic          BUSY;
  logic [AW-1:0] WAD;
  logic [7:0]    WDT;
  logic          WE;
  logic [3:0]    SEL;
  logic          READY;
  logic          ERR;

  modport master (
    output DL_EN, DL_WR, DL_DT,
    input  BUSY, WAD, WDT, WE, SEL, READY, ERR
  );

  modport slave (
    input  DL_EN, DL_WR, DL_DT,
    output BUSY, WAD, WDT, WE, SEL, READY, ERR
  );
endinterface

// File: rtl/rom_dl_writer.sv
// Writes the HPS download byte stream into four consecutive ROM regions.
// Each accepted byte produces one WE cycle carrying the region-local
// address, the data and a one-hot region select; the ROMs capture these
// on the falling edge inside that cycle.
module rom_dl_writer #(
  parameter int              AW    = 16,
  parameter logic [AW-1:0]   B1    = 16'h4000,
  parameter logic [AW-1:0]   B2    = 16'h8000,
  parameter logic [AW-1:0]   B3    = 16'hA000,
  parameter int unsigned     TOTAL = 32'hC000
) (
  input logic             CL,
  input logic             RST,
  rom_dl_writer_if.slave  bus
);

  // TOTAL may equal 2**AW, so the end-of-image test uses one extra bit.
  localparam logic [AW:0] TOTAL_W = TOTAL[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          en_q;
  logic          busy;
  logic          we;
  logic          ready;
  logic          err;
  logic [AW-1:0] wad;
  logic [7:0]    wdt;
  logic [3:0]    sel;

  logic [1:0]    region;
  logic [AW-1:0] base;
  logic [AW:0]   cnt_inc;
  logic          en_rise;

  // Region lookup and the widened next count for the current byte counter.
  always_comb begin
    region  = 2'd0;
    base    = '0;
    if (cnt >= B3) begin
      region = 2'd3;
      base   = B3;
    end else if (cnt >= B2) begin
      region = 2'd2;
      base   = B2;
    end else if (cnt >= B1) begin
      region = 2'd1;
      base   = B1;
    end
    cnt_inc = {1'b0, cnt} + {{AW{1'b0}}, 1'b1};
    en_rise = bus.DL_EN & ~en_q;
  end

  // Session FSM with all outputs registered; a WRITE cycle always runs to
  // completion, so a dropped DL_EN is only acted on from LOAD or DONE.
  always_ff @(posedge CL or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
      busy  <= 1'b0;
      we    <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
      wad   <= '0;
      wdt   <= '0;
      sel   <= '0;
    end else begin
      en_q <= bus.DL_EN;
      case (state)
        IDLE: begin
          if (en_rise) begin
            state <= LOAD;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (!bus.DL_EN) begin
            state <= IDLE;
          end else if (bus.DL_WR) begin
            state <= WRITE;
            wdt   <= bus.DL_DT;
            sel   <= 4'b0001 << region;
            wad   <= cnt - base;
            we    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        WRITE: begin
          we   <= 1'b0;
          busy <= 1'b0;
          cnt  <= cnt_inc[AW-1:0];
          if (cnt_inc == TOTAL_W) begin
            state <= DONE;
            ready <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        DONE: begin
          if (!bus.DL_EN) begin
            state <= IDLE;
          end else if (bus.DL_WR) begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY  = busy;
  assign bus.WE    = we;
  assign bus.WAD   = wad;
  assign bus.WDT   = wdt;
  assign bus.SEL   = sel;
  assign bus.READY = ready;
  assign bus.ERR   = err;

endmodule

// File: tb/tb_rom_dl_writer.sv
// Self-checking bench for rom_dl_writer, using a scaled-down image
// (1 KiB, TOTAL = 2**AW) so a full load stays short.
module tb_rom_dl_writer;

  localparam int AW    = 10;
  localparam int B1    = 'h100;
  localparam int B2    = 'h200;
  localparam int B3    = 'h300;
  localparam int TOTAL = 'h400;
  localparam int RW    = 4 + AW + 8;

  logic CL;
  logic RST;

  rom_dl_writer_if #(.AW(AW)) bus ();

  rom_dl_writer #(
    .AW(AW),
    .B1(10'h100),
    .B2(10'h200),
    .B3(10'h300),
    .TOTAL(TOTAL)
  ) dut (
    .CL(CL),
    .RST(RST),
    .bus(bus)
  );

  initial CL = 1'b0;
  always #5 CL = ~CL;

  int total;
  int bad;
  int sess_cnt;

  logic [RW-1:0] mon_q[$];
  logic [RW-1:0] exp_q[$];

  // Every WE pulse as seen by the ROMs at the falling edge.
  always @(negedge CL) begin
    if (bus.WE === 1'b1) mon_q.push_back({bus.SEL, bus.WAD, bus.WDT});
  end

  typedef struct {
    int            idx;
    logic [3:0]    sel;
    logic [AW-1:0] wad;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: byte number idx of a session lands in the highest region
  // whose base does not exceed idx, at offset idx - base.
  function automatic logic [RW-1:0] model(input int idx, input logic [7:0] d);
    int bases[4];
    int r;
    logic [3:0]    s;
    logic [AW-1:0] a;
    bases[0] = 0; bases[1] = B1; bases[2] = B2; bases[3] = B3;
    r = 0;
    for (int k = 1; k < 4; k++) if (idx >= bases[k]) r = k;
    s = 4'b0001 << r;
    a = AW'(idx - bases[r]);
    return {s, a, d};
  endfunction

  // Offer one byte and hold it until the writer has taken it and BUSY fell.
  task automatic send(input logic [7:0] d);
    bit ok;
    exp_q.push_back(model(sess_cnt, d));
    sess_cnt++;
    bus.DL_DT = d;
    bus.DL_WR = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.BUSY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic sb_check(input string nm);
    int n;
    check({nm, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({nm, "_write"}, 32'(mon_q[i]), 32'(exp_q[i]));
    $display("phase %s: %0d writes compared", nm, n);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_we"},    32'(bus.WE),    32'd0);
    check({nm, "_busy"},  32'(bus.BUSY),  32'd0);
    check({nm, "_wad"},   32'(bus.WAD),   32'd0);
    check({nm, "_wdt"},   32'(bus.WDT),   32'd0);
    check({nm, "_sel"},   32'(bus.SEL),   32'd0);
    check({nm, "_ready"}, 32'(bus.READY), 32'd0);
    check({nm, "_err"},   32'(bus.ERR),   32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    total = 0;
    bad = 0;
    sess_cnt = 0;
    vecs[0] = '{0,      4'b0001, 10'h000};
    vecs[1] = '{B1 - 1, 4'b0001, 10'h0FF};
    vecs[2] = '{B1,     4'b0010, 10'h000};
    vecs[3] = '{B2 - 1, 4'b0010, 10'h0FF};
    vecs[4] = '{B2,     4'b0100, 10'h000};
    vecs[5] = '{B3 - 1, 4'b0100, 10'h0FF};
    vecs[6] = '{B3,     4'b1000, 10'h000};
    vecs[7] = '{TOTAL - 1, 4'b1000, 10'h0FF};

    bus.DL_EN = 1'b0;
    bus.DL_WR = 1'b0;
    bus.DL_DT = 8'h00;
    RST = 1'b1;
    tick();
    tick();
    check_zero("reset");
    RST = 1'b0;
    tick();

    // DL_EN rise with DL_WR already high: only the session starts.
    bus.DL_EN = 1'b1;
    bus.DL_WR = 1'b1;
    bus.DL_DT = 8'h11;
    tick();
    check("rise_only_we", 32'(bus.WE), 32'd0);
    tick();
    check("b0_we",   32'(bus.WE),   32'd1);
    check("b0_busy", 32'(bus.BUSY), 32'd1);
    check("b0_wad",  32'(bus.WAD),  32'd0);
    check("b0_wdt",  32'(bus.WDT),  32'h11);
    check("b0_sel",  32'(bus.SEL),  32'b0001);
    tick();
    check("b0_we_fall",   32'(bus.WE),   32'd0);
    check("b0_busy_fall", 32'(bus.BUSY), 32'd0);
    bus.DL_DT = 8'h22;
    tick();
    check("b1_we",   32'(bus.WE),   32'd1);
    check("b1_busy", 32'(bus.BUSY), 32'd1);
    check("b1_wad",  32'(bus.WAD),  32'd1);
    check("b1_wdt",  32'(bus.WDT),  32'h22);
    check("b1_sel",  32'(bus.SEL),  32'b0001);
    tick();
    check("held_pulses", 32'(mon_q.size()), 32'd2);
    mon_q.delete();
    $display("phase held_wr: two bytes");

    // Abort after 100 bytes.
    sess_cnt = 2;
    for (int i = 2; i < 100; i++) send(8'($urandom));
    bus.DL_WR = 1'b0;
    bus.DL_EN = 1'b0;
    tick();
    tick();
    check("abort_ready", 32'(bus.READY), 32'd0);
    sb_check("abort");

    // Fresh session restarts at region 0, offset 0.
    bus.DL_EN = 1'b1;
    tick();
    sess_cnt = 0;
    send(8'h5A);
    bus.DL_WR = 1'b0;
    sb_check("restart");

    // Reset while a WE cycle is in flight.
    bus.DL_DT = 8'hC3;
    bus.DL_WR = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.WE === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_we_seen", 32'(ok), 32'd1);
    RST = 1'b1;
    bus.DL_EN = 1'b0;
    #1;
    check_zero("rst_mid");
    mon_q.delete();
    exp_q.delete();
    tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("rst_no_we", 32'(mon_q.size()), 32'd0);
    bus.DL_WR = 1'b0;

    // Full image load with random data and random gaps.
    bus.DL_EN = 1'b1;
    tick();
    sess_cnt = 0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i == TOTAL - 1) check("ready_before_last", 32'(bus.READY), 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        bus.DL_WR = 1'b0;
        tick();
      end
      send(8'($urandom));
    end
    check("ready_after_last", 32'(bus.READY), 32'd1);
    check("we_after_last",    32'(bus.WE),    32'd0);
    check("full_count", 32'(mon_q.size()), 32'(TOTAL));
    for (int v = 0; v < 8; v++) begin
      if (mon_q.size() > vecs[v].idx) begin
        check("bound_sel", 32'(mon_q[vecs[v].idx][RW-1 -: 4]), 32'(vecs[v].sel));
        check("bound_wad", 32'(mon_q[vecs[v].idx][AW+7 -: AW]), 32'(vecs[v].wad));
      end else begin
        check("bound_present", 32'(mon_q.size()), 32'(vecs[v].idx + 1));
      end
    end
    sb_check("full");

    // Byte offered after the image is complete.
    bus.DL_DT = 8'h77;
    bus.DL_WR = 1'b1;
    tick();
    tick();
    tick();
    check("done_err",   32'(bus.ERR),      32'd1);
    check("done_ready", 32'(bus.READY),    32'd1);
    check("done_no_we", 32'(mon_q.size()), 32'd0);
    bus.DL_WR = 1'b0;
    bus.DL_EN = 1'b0;
    tick();
    tick();
    check("idle_ready_kept", 32'(bus.READY), 32'd1);
    bus.DL_EN = 1'b1;
    tick();
    check("new_ready_clear", 32'(bus.READY), 32'd0);
    check("new_err_clear",   32'(bus.ERR),   32'd0);
    sess_cnt = 0;
    send(8'hA5);
    bus.DL_WR = 1'b0;
    sb_check("after_done");
    bus.DL_EN = 1'b0;
    tick();
    tick();

    // Random short sessions, each aborted before the image completes.
    for (int s = 0; s < 6; s++) begin
      bus.DL_EN = 1'b1;
      tick();
      sess_cnt = 0;
      n = $urandom_range(1, 300);
      for (int i = 0; i < n; i++) begin
        bus.DL_WR = 1'b0;
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        send(8'($urandom));
      end
      bus.DL_WR = 1'b0;
      bus.DL_EN = 1'b0;
      tick();
      tick();
      check("rand_ready", 32'(bus.READY), 32'd0);
      sb_check("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_dl_writer.md
# rom_dl_writer

Download-side writer that fills the core's download-loaded ROMs. It accepts the HPS download byte stream and writes each byte into one of four ROM regions. For each byte it produces the region's local address, data, a one-hot region select and a write strobe. The outputs drive the ROMs' write ports, which capture on the falling clock edge. The block sits between the download interface and the ROM array, and reports load completion and overflow to the reset/boot logic.

## Interface

Parameters:
- AW, 16: download byte-counter and address width.
- B1, 16'h4000: first byte of region 1 (region 0 starts at 0).
- B2, 16'h8000: first byte of region 2.
- B3, 16'hA000: first byte of region 3.
- TOTAL, 16'hC000: total image size in bytes. Requires 0 < B1 < B2 < B3 < TOTAL ≤ 2**AW.

Ports:
- CL  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DL_EN  in  1  download session active (level).
- DL_WR  in  1  byte valid; accepted only when BUSY=0 in LOAD.
- DL_DT  in  8  download byte.
- BUSY  out  1  high during the WRITE cycle; the source holds DL_WR/DL_DT until BUSY=0.
- WAD  out  AW  region-local write address (count − region base).
- WDT  out  8  write data.
- WE  out  1  write strobe; high exactly one CL cycle per byte.
- SEL  out  4  one-hot region select; valid whenever WE=1.
- READY  out  1  sticky flag: full image loaded.
- ERR  out  1  sticky flag: byte offered after TOTAL reached.

## Operation

- Byte counter CNT, AW bits, internal.
- States:
  - IDLE: waiting for a session.
  - LOAD: waiting for a byte.
  - WRITE: strobe cycle.
  - DONE: image complete.
- IDLE → LOAD on the rising edge of DL_EN (DL_EN=1 while the previous registered DL_EN=0). On this transition: CNT←0, READY←0, ERR←0.
- LOAD → WRITE when DL_WR=1. Same edge registers:
  - WDT←DL_DT.
  - SEL←region of CNT: 0 if CNT<B1, 1 if CNT<B2, 2 if CNT<B3, else 3.
  - WAD←CNT − base (AW-bit unsigned subtract).
  - WE←1, BUSY←1.
- WRITE → LOAD after one cycle: WE←0, BUSY←0, CNT←CNT+1.
- WRITE → DONE instead if CNT+1 == TOTAL; also READY←1.
- DONE:
  - DL_WR=1 sets ERR←1. No write, WE stays 0.
  - DL_EN=0 → IDLE. READY is retained.
- Any state except DONE: DL_EN=0 → IDLE, READY stays 0 (aborted load).
- A WRITE cycle in progress always completes its strobe, even if DL_EN drops. The IDLE transition occurs on the following edge.
- WAD, WDT and SEL hold their last values outside WRITE. Only WE qualifies them.
- CNT never wraps, because TOTAL ≤ 2**AW is enforced by DONE.

## Timing

- Reset (async assert, sync release): state IDLE, CNT=0, WE=0, BUSY=0, WAD=0, WDT=0, SEL=0, READY=0, ERR=0.
- Latency:
  - Byte accepted at edge N → WE/WAD/WDT/SEL valid from edge N to edge N+1. The negedge mid-cycle captures stable values.
  - BUSY falls at edge N+1.
  - Next byte is accepted no earlier than edge N+2.
  - Maximum throughput: one byte per 2 cycles.
- DL_WR held high continuously is accepted once per LOAD visit, with no duplicate writes. The source must change DL_DT only after BUSY falls.
- DL_EN rising and DL_WR on the same edge: this edge performs IDLE→LOAD only. The byte is accepted on the next edge if DL_WR is still high.
- READY rises on the edge ending the last WRITE cycle (same edge WE falls).
- Region boundary: byte at CNT=B1−1 gets SEL=0001 with WAD=B1−1. Byte at CNT=B1 gets SEL=0010 with WAD=0.

## Test plan

- Reset mid-WRITE (assert RST while WE=1) → all outputs 0 immediately; after release, state is IDLE and no WE occurs until a new DL_EN rise.
- DL_EN↑, then bytes 0x11, 0x22 with DL_WR held high → two WE pulses: WAD=0/WDT=0x11, then WAD=1/WDT=0x22, both SEL=0001. Pulses are 2 cycles apart, with BUSY high during each WE cycle.
- Stream to CNT=0x3FFF, 0x4000, 0x9FFF, 0xA000 → SEL/WAD respectively: 0001/0x3FFF, 0010/0x0000, 0100/0x1FFF, 1000/0x0000.
- Full 0xC000-byte load → exactly 49152 WE pulses. READY=1 on the edge after the last pulse; then DL_EN↓ → READY stays 1; next DL_EN↑ → READY=0, CNT=0.
- After DONE, assert DL_WR with DL_EN=1 → ERR=1, no WE, READY remains 1.
- Abort: DL_EN↓ after 100 bytes → IDLE, READY=0. A fresh session restarts at WAD=0, SEL=0001.
